key_wave_sel: RTL and testbench

Upstream control stage of the DDS signal generator. It takes the four raw, active-low push-button inputs. Each button is synchronised and debounced independently, producing one single-cycle press event per physical press. The events drive a registered one-hot waveform selector that feeds the `wave_sel[3:0]` input of the DDS waveform/phase controller. It also emits a one-cycle change strobe for status LEDs or phase-accumulator reset.

---
 rtl/dds_pkg.sv | 28 ++
 rtl/key_filter.sv | 61 ++++++
 rtl/key_wave_sel.sv | 70 +++++++
 tb/tb_key_wave_sel.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// ============================================================================
// Module      : dds_pkg
// Description : Constants and the one-hot waveform-select type shared by the
//               key front end and the DDS waveform/phase controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_pkg;

    localparam int KEY_NUM = 4;

    typedef logic [KEY_NUM-1:0] wave_t;

    localparam wave_t WAVE_SINE   = 4'b0001;
    localparam wave_t WAVE_SQUARE = 4'b0010;
    localparam wave_t WAVE_TRI    = 4'b0100;
    localparam wave_t WAVE_SAW    = 4'b1000;
    localparam wave_t WAVE_RST    = WAVE_SINE;

    // Isolates the lowest set bit: two's complement trick keeps only that bit.
    function automatic wave_t onehot_lowest(input wave_t f);
        return f & (~f + wave_t'(1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_filter.sv
// ============================================================================
// Module      : key_filter
// Description : One push button: 2-FF synchroniser, saturating debounce
//               counter and a registered single-cycle press flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_filter #(
    parameter int CNT_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag
);

    localparam int             CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(CNT_MAX);
    localparam logic [CW-1:0]  C_CNT_ARM = CW'(CNT_MAX - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flag_q;
    logic          flag_d;
    logic          key_s;

    assign key_s = sync_q[1];

    // Counter saturates at CNT_MAX so a held key cannot re-fire the flag.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = 1'b0;
        if (key_s) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            flag_d = (cnt_q == C_CNT_ARM);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_in};
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign key_flag = flag_q;

endmodule

`default_nettype wire

// File: rtl/key_wave_sel.sv
// ============================================================================
// Module      : key_wave_sel
// Description : Four debounced buttons driving a registered one-hot waveform
//               selector with a one-cycle change strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_wave_sel #(
    parameter int CNT_MAX = 999_999,
    parameter int KEY_NUM = dds_pkg::KEY_NUM
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] wave_sel,
    output logic               wave_chg,
    output logic [KEY_NUM-1:0] key_flag
);

    import dds_pkg::wave_t;
    import dds_pkg::WAVE_RST;
    import dds_pkg::onehot_lowest;

    wave_t flag_w;
    wave_t sel_d;
    logic  chg_d;
    wave_t wave_sel_q;
    logic  wave_chg_q;

    generate
        for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
            key_filter #(
                .CNT_MAX (CNT_MAX)
            ) u_key_filter (
                .sys_clk  (sys_clk),
                .sys_rst  (sys_rst),
                .key_in   (key[i]),
                .key_flag (flag_w[i])
            );
        end
    endgenerate

    // Lowest-index press wins; simultaneous higher-index presses are dropped.
    always_comb begin
        sel_d = wave_sel_q;
        chg_d = 1'b0;
        if (|flag_w) begin
            sel_d = onehot_lowest(flag_w);
            chg_d = (sel_d != wave_sel_q);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wave_sel_q <= WAVE_RST;
            wave_chg_q <= 1'b0;
        end else begin
            wave_sel_q <= sel_d;
            wave_chg_q <= chg_d;
        end
    end

    assign wave_sel = wave_sel_q;
    assign wave_chg = wave_chg_q;
    assign key_flag = flag_w;

endmodule

`default_nettype wire

// File: tb/tb_key_wave_sel.sv
// ============================================================================
// Module      : tb_key_wave_sel
// Description : Self-checking bench for key_wave_sel against a run-length
//               reference model of the button/selector behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_wave_sel;

    localparam int CNT_MAX = 4;

    logic       clk     = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] key     = 4'hF;
    logic [3:0] wave_sel;
    logic       wave_chg;
    logic [3:0] key_flag;

    int checks = 0;
    int errors = 0;

    key_wave_sel #(
        .CNT_MAX (CNT_MAX),
        .KEY_NUM (4)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (sys_rst),
        .key      (key),
        .wave_sel (wave_sel),
        .wave_chg (wave_chg),
        .key_flag (key_flag)
    );

    always #5 clk = ~clk;

    // Reference model: a press fires when the raw pin has been sampled low
    // for exactly CNT_MAX edges, seen two edges later through the synchroniser.
    int         m_run1 [4];
    int         m_run2 [4];
    logic       m_rst1 = 1'b1;
    logic [3:0] m_flag = 4'h0;
    logic [3:0] m_sel  = 4'b0001;
    logic       m_chg  = 1'b0;

    function automatic logic [3:0] lowest_pick(input logic [3:0] f);
        for (int i = 0; i < 4; i++) begin
            if (f[i]) return 4'(1 << i);
        end
        return 4'h0;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_run1[i] = 0;
            m_run2[i] = 0;
        end
    end

    always @(posedge clk) begin
        if (sys_rst) begin
            m_sel <= 4'b0001;
            m_chg <= 1'b0;
        end else if (m_flag != 4'h0) begin
            m_sel <= lowest_pick(m_flag);
            m_chg <= (lowest_pick(m_flag) != m_sel);
        end else begin
            m_chg <= 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            m_flag[i] <= !sys_rst && !m_rst1 && (m_run2[i] == CNT_MAX);
            m_run2[i] <= m_run1[i];
            m_run1[i] <= (sys_rst || key[i]) ? 0 : ((m_run1[i] < 1000) ? m_run1[i] + 1 : 1000);
        end
        m_rst1 <= sys_rst;
    end

    // Advance one clock; return positioned on the falling edge after it.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        key     = 4'hF;
        repeat (3) cyc();
        checks++;
        if (wave_sel !== 4'b0001) begin
            errors++;
            $display("FAIL reset_sel: got %b exp 0001", wave_sel);
        end
        checks++;
        if (wave_chg !== 1'b0 || key_flag !== 4'h0) begin
            errors++;
            $display("FAIL reset_out: chg %b flag %b exp 0 0000", wave_chg, key_flag);
        end
        sys_rst = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_clean_press();
        int extra_flags = 0;
        key[2] = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            cyc();
            checks++;
            if ({key_flag, wave_sel, wave_chg} !== {m_flag, m_sel, m_chg}) begin
                errors++;
                $display("FAIL clean_model k=%0d: got %b/%b/%b exp %b/%b/%b",
                         k, key_flag, wave_sel, wave_chg, m_flag, m_sel, m_chg);
            end
            if (k == 5 && key_flag !== 4'h0) begin
                errors++;
                $display("FAIL clean_early: flag %b exp 0000 at edge 5", key_flag);
            end
            if (k == 6) begin
                checks++;
                if (key_flag !== 4'b0100) begin
                    errors++;
                    $display("FAIL clean_flag: got %b exp 0100", key_flag);
                end
            end
            if (k == 7) begin
                checks++;
                if (wave_sel !== 4'b0100 || wave_chg !== 1'b1) begin
                    errors++;
                    $display("FAIL clean_sel: sel %b chg %b exp 0100 1", wave_sel, wave_chg);
                end
            end
            if (k == 8) begin
                checks++;
                if (wave_chg !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_chg_drop: got %b exp 0", wave_chg);
                end
            end
            if (k > 6 && key_flag !== 4'h0) extra_flags++;
        end
        checks++;
        if (extra_flags !== 0) begin
            errors++;
            $display("FAIL clean_hold: %0d extra flag cycles exp 0", extra_flags);
        end
        key = 4'hF;
        repeat (4) cyc();
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        key = 4'b0101;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if ({key_flag, wave_sel, wave_chg} !== {m_flag, m_sel, m_chg}) begin
                errors++;
                $display("FAIL simul_model k=%0d: got %b/%b/%b exp %b/%b/%b",
                         k, key_flag, wave_sel, wave_chg, m_flag, m_sel, m_chg);
            end
            if (k == 6) begin
                checks++;
                if (key_flag !== 4'b1010) begin
                    errors++;
                    $display("FAIL simul_flag: got %b exp 1010", key_flag);
                end
            end
            if (wave_chg === 1'b1) pulses++;
        end
        checks++;
        if (wave_sel !== 4'b0010 || pulses !== 1) begin
            errors++;
            $display("FAIL simul_sel: sel %b pulses %0d exp 0010 1", wave_sel, pulses);
        end
        key = 4'hF;
        repeat (4) cyc();
    endtask

    task automatic test_repress();
        int chg_seen = 0;
        int flag0    = 0;
        key[0] = 1'b0;
        repeat (9) cyc();
        checks++;
        if (wave_sel !== 4'b0001) begin
            errors++;
            $display("FAIL repress_setup: sel %b exp 0001", wave_sel);
        end
        key = 4'hF;
        repeat (4) cyc();
        key[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if ({key_flag, wave_sel, wave_chg} !== {m_flag, m_sel, m_chg}) begin
                errors++;
                $display("FAIL repress_model k=%0d: got %b/%b/%b exp %b/%b/%b",
                         k, key_flag, wave_sel, wave_chg, m_flag, m_sel, m_chg);
            end
            if (wave_chg !== 1'b0) chg_seen++;
            if (key_flag[0] === 1'b1) flag0++;
        end
        checks++;
        if (flag0 !== 1 || chg_seen !== 0 || wave_sel !== 4'b0001) begin
            errors++;
            $display("FAIL repress: flag0 %0d chg %0d sel %b exp 1 0 0001", flag0, chg_seen, wave_sel);
        end
        key = 4'hF;
        repeat (4) cyc();
    endtask

    task automatic test_bounce();
        logic [11:0] pattern = 12'b1110_0010_0011; // bit k: key[1] level on cycle k
        int flags = 0;
        for (int k = 0; k < 12; k++) begin
            key[1] = pattern[k];
            cyc();
            checks++;
            if ({key_flag, wave_sel, wave_chg} !== {m_flag, m_sel, m_chg}) begin
                errors++;
                $display("FAIL bounce_model k=%0d: got %b/%b/%b exp %b/%b/%b",
                         k, key_flag, wave_sel, wave_chg, m_flag, m_sel, m_chg);
            end
            if (key_flag !== 4'h0) flags++;
        end
        key = 4'hF;
        repeat (3) cyc();
        checks++;
        if (flags !== 0 || wave_sel !== 4'b0001) begin
            errors++;
            $display("FAIL bounce: flags %0d sel %b exp 0 0001", flags, wave_sel);
        end
        key[1] = 1'b0;
        repeat (8) cyc();
        checks++;
        if (wave_sel !== 4'b0010) begin
            errors++;
            $display("FAIL bounce_steady: sel %b exp 0010", wave_sel);
        end
        key = 4'hF;
        repeat (4) cyc();
    endtask

    task automatic test_reset_mid_count();
        int rst_flags = 0;
        key[3] = 1'b0;
        repeat (5) cyc();
        sys_rst = 1'b1;
        repeat (2) begin
            cyc();
            if (key_flag !== 4'h0) rst_flags++;
        end
        checks++;
        if (rst_flags !== 0 || wave_sel !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_during: flags %0d sel %b exp 0 0001", rst_flags, wave_sel);
        end
        sys_rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            checks++;
            if ({key_flag, wave_sel, wave_chg} !== {m_flag, m_sel, m_chg}) begin
                errors++;
                $display("FAIL midrst_model k=%0d: got %b/%b/%b exp %b/%b/%b",
                         k, key_flag, wave_sel, wave_chg, m_flag, m_sel, m_chg);
            end
            if (k == 5 && key_flag !== 4'h0) begin
                errors++;
                $display("FAIL midrst_early: flag %b exp 0000", key_flag);
            end
            if (k == 6) begin
                checks++;
                if (key_flag !== 4'b1000) begin
                    errors++;
                    $display("FAIL midrst_flag: got %b exp 1000", key_flag);
                end
            end
            if (k == 7) begin
                checks++;
                if (wave_sel !== 4'b1000) begin
                    errors++;
                    $display("FAIL midrst_sel: got %b exp 1000", wave_sel);
                end
            end
        end
        key = 4'hF;
        repeat (4) cyc();
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            key = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 8)) begin
                cyc();
                checks++;
                if ({key_flag, wave_sel, wave_chg} !== {m_flag, m_sel, m_chg}) begin
                    errors++;
                    $display("FAIL random_model s=%0d: got %b/%b/%b exp %b/%b/%b",
                             s, key_flag, wave_sel, wave_chg, m_flag, m_sel, m_chg);
                end
                if (!$onehot(wave_sel)) begin
                    errors++;
                    $display("FAIL random_onehot: sel %b", wave_sel);
                end
            end
        end
        key = 4'hF;
        repeat (4) cyc();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_simultaneous();
        test_repress();
        test_bounce();
        test_reset_mid_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
